// File: rtl/pwm_pkg.sv
// Shared widths, ramp FSM state type and the default duty ceiling for the PWM duty ramp.
// Latency: n/a (declarations only).  Backpressure: n/a.
package pwm_pkg;
  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX_DEF = 8'd230;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;
endpackage

// File: rtl/pwm_tick_div.sv
// Divides period_end pulses by TICK_DIV into ramp step ticks; counter is cleared while the ramp is idle.
// Latency: tick is combinational from period_end.  Backpressure: none; ena=0 freezes the counter.
module pwm_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       active,
  input  logic       period_end,
  output logic       tick,
  output logic [3:0] div_cnt
);
  localparam logic [3:0] LAST = 4'(TICK_DIV - 1);

  assign tick = ena & active & period_end & (div_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (ena) begin
      if (!active) begin
        div_cnt <= '0;
      end else if (period_end) begin
        div_cnt <= tick ? 4'd0 : div_cnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/pwm_duty_ramp.sv
// Ramps duty_out toward a captured target by step every TICK_DIV PWM periods; DUTY_LIMIT_EN clamps targets to DUTY_MAX.
// Latency: duty_out/duty_load update one cycle after the ticking period_end.  Backpressure: none; ena=0 holds all state.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int                TICK_DIV = 4,
  parameter logic [DUTY_W-1:0] DUTY_MAX = DUTY_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_valid,
  input  logic [3:0]        step,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_load,
  output logic              busy
);
  ramp_state_t       state, state_nxt;
  logic [DUTY_W-1:0] target_q, target_cap, duty_nxt, up_val, down_val;
  logic [DUTY_W:0]   sum9, diff9;
  logic [3:0]        step_eff, div_cnt;
  logic              tick;

`ifdef DUTY_LIMIT_EN
  assign target_cap = (target_duty > DUTY_MAX) ? DUTY_MAX : target_duty;
`else
  assign target_cap = target_duty;
`endif

  assign step_eff = (step == 4'd0) ? 4'd1 : step;
  assign busy     = (state != IDLE);

  pwm_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .active     (busy),
    .period_end (period_end),
    .tick       (tick),
    .div_cnt    (div_cnt)
  );

  // Ninth bit catches both overflow past 255 and underflow below 0.
  always_comb begin
    sum9     = {1'b0, duty_out} + {5'b0, step_eff};
    diff9    = {1'b0, duty_out} - {5'b0, step_eff};
    up_val   = (sum9 >= {1'b0, target_q}) ? target_q : sum9[DUTY_W-1:0];
    down_val = (diff9[DUTY_W] || (diff9[DUTY_W-1:0] <= target_q)) ? target_q : diff9[DUTY_W-1:0];
    duty_nxt = duty_out;
    case (state)
      RAMP_UP:   duty_nxt = up_val;
      RAMP_DOWN: duty_nxt = down_val;
      default:   duty_nxt = duty_out;
    endcase
  end

  always_comb begin
    state_nxt = IDLE;
    if (target_q > duty_out) begin
      state_nxt = RAMP_UP;
    end else if (target_q < duty_out) begin
      state_nxt = RAMP_DOWN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target_q  <= '0;
      duty_out  <= '0;
      duty_load <= 1'b0;
    end else begin
      duty_load <= 1'b0;
      if (ena) begin
        state <= state_nxt;
        if (target_valid) begin
          target_q <= target_cap;
        end
        if (tick) begin
          duty_out  <= duty_nxt;
          duty_load <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/pwm_duty_ramp.md
PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning the number of period_end pulses per ramp step (legal 1..16).
REQ-002 SHALL have parameter DUTY_MAX, default 8'd230, meaning the clamp ceiling used only when DUTY_LIMIT_EN is defined.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset; asynchronous assert, active-low.
REQ-005 SHALL have port ena, input, 1, the design-select; when low, all state is held.
REQ-006 SHALL have port target_duty, input, 8, the requested duty.
REQ-007 SHALL have port target_valid, input, 1, a one-cycle strobe that captures target_duty.
REQ-008 SHALL have port step, input, 4, the duty increment per ramp step; 0 is treated as 1.
REQ-009 SHALL have port period_end, input, 1, a one-cycle pulse from the downstream PWM core at each PWM period boundary.
REQ-010 SHALL have port duty_out, output, 8, the current duty fed to the PWM core.
REQ-011 SHALL have port duty_load, output, 1, a one-cycle strobe asserted in the same cycle that duty_out takes a new value.
REQ-012 SHALL have port busy, output, 1, high while duty_out != captured target.

Function
REQ-013 SHALL capture target_duty into target_q on a cycle where ena=1 and target_valid=1; the capture is visible the next cycle.
REQ-014 SHALL implement FSM states IDLE, RAMP_UP and RAMP_DOWN.
REQ-015 SHALL evaluate FSM transitions each cycle from target_q versus duty_out: equal->IDLE, greater->RAMP_UP, less->RAMP_DOWN.
REQ-016 SHALL count period_end pulses in div_cnt (0..TICK_DIV-1) only while the state is not IDLE and ena=1.
REQ-017 SHALL generate a step tick when period_end=1 and div_cnt=TICK_DIV-1, and SHALL then wrap div_cnt to 0.
REQ-018 SHALL clear div_cnt to 0 on entering IDLE.
REQ-019 SHALL, on a step tick in RAMP_UP, set duty_out to min(duty_out+step, target_q) using 9-bit arithmetic, with no wrap past 255.
REQ-020 SHALL, on a step tick in RAMP_DOWN, set duty_out to max(duty_out-step, target_q) with no underflow below 0.
REQ-021 SHALL make the duty_out update and the duty_load pulse take effect on the clock edge following the tick cycle (latency 1 cycle from period_end).
REQ-022 SHALL, when target_valid and a step tick occur in the same cycle, compute the step with the old target_q; the new target governs from the next cycle.
REQ-023 SHALL, on a target change mid-ramp that reverses direction, switch state the next cycle without resetting div_cnt and without overshooting target_q.
REQ-024 SHALL, when ena=0, ignore target_valid and period_end and hold duty_out, div_cnt, state and target_q; duty_load SHALL be 0.
REQ-025 SHALL drive busy combinationally as (state != IDLE).

Reset
REQ-026 SHALL, on rst_n low, immediately set duty_out=0, target_q=0, div_cnt=0, state=IDLE, duty_load=0 and busy=0, including when reset is asserted mid-ramp.
REQ-027 SHALL, after reset release, take no step until a new target is captured.

Configuration
REQ-028 SHALL, when DUTY_LIMIT_EN is defined, clamp captured targets to min(target_duty, DUTY_MAX), so that duty_out never exceeds DUTY_MAX.
REQ-029 SHALL, when DUTY_LIMIT_EN is undefined, capture target_duty unmodified and not use DUTY_MAX.

Structure
REQ-030 SHALL place DUTY_W=8, the FSM state enum type and the DUTY_MAX default constant in shared package pwm_pkg.
REQ-031 SHALL implement the period_end divider (div_cnt, tick generation, clear-on-idle) as sub-module pwm_tick_div.

Verification
REQ-032 SHALL cover: reset, then target 40 with step 10 and TICK_DIV 4 -> duty_out 10,20,30,40 each 4 period_end pulses apart, 4 duty_load pulses, then busy=0.
REQ-033 SHALL cover: duty 40, target 33 with step 5 -> duty_out 35 then 33 with no undershoot, then IDLE.
REQ-034 SHALL cover: duty 250, target 255 with step 15 -> duty_out 255 with no wrap; duty 3, target 0 with step 15 -> duty_out 0.
REQ-035 SHALL cover: mid-ramp up at 60 toward 200, retarget to 20 -> next tick duty_out decreases, with no step above 60.
REQ-036 SHALL cover: ena=0 for 20 period_end pulses during a ramp -> duty_out and div_cnt unchanged and no duty_load; ramp resumes when ena returns to 1.
REQ-037 SHALL cover: with DUTY_LIMIT_EN, target 255 -> final duty_out 230; rst_n low mid-ramp -> duty_out 0 asynchronously.
